// File: rtl/mips_md_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM state encoding, default width and iteration counter width.
package mips_md_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = $clog2(MD_WIDTH);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdOp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } mdState_t;

  // True for the two divide encodings.
  function automatic logic isDivideOp(input mdOp_t o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  // True for the two signed encodings.
  function automatic logic isSignedOp(input mdOp_t o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/md_negate.sv
// Conditional two's complement: out = neg ? -in : in.
// Used both to take operand magnitudes and to restore result signs.
module md_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] in,
  input  logic         neg,
  output logic [W-1:0] out
);

  // Negate only when asked; the most negative value maps onto itself.
  always_comb begin
    out = in;
    if (neg) out = ~in + W'(1);
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU) with
// MTHI/MTLO write port. One shift-add or restoring shift-subtract step per
// cycle, then a sign-fix cycle that writes HI/LO and pulses done.
// Optional feature macro: MD_DIVZERO_EN (divide-by-zero shortcut plus
// div_zero output pulse).
//
// Handshake: start is sampled only in IDLE or DONE (busy=0); while busy=1
// start is ignored. done is a one-cycle pulse in the cycle HI/LO first show
// the new result. MTHI/MTLO writes land only when busy=0 and start=0.
module mult_div_unit
  import mips_md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
`ifdef MD_DIVZERO_EN
  output logic             div_zero,
`endif
  output mdState_t         dbgState
);

  localparam int CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  mdState_t             state;
  logic [CntW-1:0]      cnt;
  logic [2*WIDTH-1:0]   acc;      // {partial/remainder, multiplier/quotient}
  logic [WIDTH-1:0]     addend;   // multiplicand or divisor magnitude
  logic                 isDiv;
  logic                 negLo;    // negate product / quotient
  logic                 negHi;    // negate remainder
`ifdef MD_DIVZERO_EN
  logic                 divZeroHit;
`endif

  mdOp_t                opSel;
  logic                 startDiv;
  logic                 startSigned;
  logic [WIDTH-1:0]     magA;
  logic [WIDTH-1:0]     magB;
  logic [WIDTH:0]       mulSum;
  logic [2*WIDTH-1:0]   mulNext;
  logic [WIDTH:0]       divTrial;
  logic [2*WIDTH-1:0]   divNext;
  logic [2*WIDTH-1:0]   prodFix;
  logic [WIDTH-1:0]     quotFix;
  logic [WIDTH-1:0]     remFix;

  assign opSel       = mdOp_t'(op);
  assign startDiv    = isDivideOp(opSel);
  assign startSigned = isSignedOp(opSel);
  assign dbgState    = state;

  md_negate #(.W(WIDTH)) uNegA (
    .in(rs_data), .neg(startSigned & rs_data[WIDTH-1]), .out(magA)
  );
  md_negate #(.W(WIDTH)) uNegB (
    .in(rt_data), .neg(startSigned & rt_data[WIDTH-1]), .out(magB)
  );
  md_negate #(.W(2*WIDTH)) uNegProd (
    .in(acc), .neg(negLo), .out(prodFix)
  );
  md_negate #(.W(WIDTH)) uNegQuot (
    .in(acc[WIDTH-1:0]), .neg(negLo), .out(quotFix)
  );
  md_negate #(.W(WIDTH)) uNegRem (
    .in(acc[2*WIDTH-1:WIDTH]), .neg(negHi), .out(remFix)
  );

  // One iteration of each algorithm; the FSM picks which to keep.
  always_comb begin
    mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    mulNext = {1'b0, acc[2*WIDTH-1:1]};
    if (acc[0]) mulNext = {mulSum, acc[WIDTH-1:1]};
    divTrial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, addend};
    divNext  = {acc[2*WIDTH-2:0], 1'b0};
    if (!divTrial[WIDTH]) divNext = {divTrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // Control FSM plus all datapath and architectural HI/LO state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      acc    <= '0;
      addend <= '0;
      isDiv  <= 1'b0;
      negLo  <= 1'b0;
      negHi  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
`ifdef MD_DIVZERO_EN
      divZeroHit <= 1'b0;
      div_zero   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MD_DIVZERO_EN
      div_zero <= 1'b0;
`endif
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state  <= ST_RUN;
            busy   <= 1'b1;
            cnt    <= '0;
            isDiv  <= startDiv;
            negLo  <= startSigned & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            negHi  <= startSigned & startDiv & rs_data[WIDTH-1];
            acc    <= startDiv ? {{WIDTH{1'b0}}, magA} : {{WIDTH{1'b0}}, magB};
            addend <= startDiv ? magB : magA;
`ifdef MD_DIVZERO_EN
            divZeroHit <= 1'b0;
            if (startDiv && (rt_data == '0)) begin
              // Skip the iterations; FIX copies the architected result.
              state      <= ST_FIX;
              divZeroHit <= 1'b1;
              acc        <= {rs_data, {WIDTH{1'b1}}};
            end
`endif
          end else begin
            state <= ST_IDLE;
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        ST_RUN: begin
          acc <= isDiv ? divNext : mulNext;
          cnt <= cnt + CntW'(1);
          if (cnt == LastCnt) state <= ST_FIX;
        end
        ST_FIX: begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
`ifdef MD_DIVZERO_EN
          if (divZeroHit) begin
            hi       <= acc[2*WIDTH-1:WIDTH];
            lo       <= acc[WIDTH-1:0];
            div_zero <= 1'b1;
          end else
`endif
          if (isDiv) begin
            hi <= remFix;
            lo <= quotFix;
          end else begin
            hi <= prodFix[2*WIDTH-1:WIDTH];
            lo <= prodFix[WIDTH-1:0];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: driver tasks push expected HI/LO and
// done cycle into queues; a monitor pops and checks on every done pulse.
module tb_mult_div_unit;
  import mips_md_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  rs_data, rt_data, wdata;
  logic          hi_we, lo_we;
  logic          busy, done;
  logic [W-1:0]  hi, lo;
  mdState_t      dbg_state;
`ifdef MD_DIVZERO_EN
  logic          div_zero;
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = 33;
`endif

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int done_count = 0;

  logic [2*W-1:0] exp_q[$];
  int             exp_cyc_q[$];
  bit             exp_chk_q[$];
  bit             exp_dz_q[$];

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
`ifdef MD_DIVZERO_EN
    .div_zero(div_zero),
`endif
    .dbgState(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a negedge; start is sampled at the next posedge (E0).
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] exp, input int lat, input bit chk, input bit dz);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    exp_q.push_back(exp);
    exp_cyc_q.push_back(cyc + lat);
    exp_chk_q.push_back(chk);
    exp_dz_q.push_back(dz);
    start = 1'b0;
    op = 2'($urandom_range(0, 3));
    rs_data = $urandom;
    rt_data = $urandom;
    @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!done) begin
      failed++;
      $display("FAIL %s_timeout: done not seen after %0d cycles, required within 60", name, n);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_count++;
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required no pending op", cyc);
      end else begin
        logic [2*W-1:0] e;
        int ec;
        bit chk, dz;
        e = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        chk = exp_chk_q.pop_front();
        dz = exp_dz_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(ec));
        if (chk) check("hi_lo", {hi, lo}, e);
`ifdef MD_DIVZERO_EN
        check("div_zero", 64'(div_zero), 64'(dz));
`else
        if (dz && !chk) check("busy_at_done", 64'(busy), 64'd0);
`endif
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_hilo", {hi, lo}, 0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // MULTU 7*8 with busy profile over cycles 1..33
    issue(2'b01, 32'd7, 32'd8, 64'd56, 33, 1, 0);
    for (int k = 1; k <= 33; k++) begin
      tests++;
      if (busy !== 1'b1) begin
        failed++;
        $display("FAIL busy_profile: cycle %0d busy=%0b required 1", k, busy);
      end
      @(negedge clk);
    end
    wait_done("multu_7x8");
    check("busy_low_at_done", 64'(busy), 0);

    // back-to-back ops, each started in the DONE cycle of the previous one
    issue(2'b00, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 33, 1, 0);
    wait_done("mult_neg2x3");
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33, 1, 0);
    wait_done("multu_max");
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, 1, 0);
    wait_done("div_m7_2");
    issue(2'b10, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33, 1, 0);
    wait_done("div_7_m2");
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33, 1, 0);
    wait_done("div_min_m1");
    issue(2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1, 0);
    wait_done("divu_100_7");

    // start and MTHI/MTLO while busy are ignored
    issue(2'b11, 32'd1000, 32'd10, {32'd0, 32'd100}, 33, 1, 0);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'b00; rs_data = 32'd3; rt_data = 32'd5;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check("hi_held_in_run", 64'(hi), 64'd2);
    check("lo_held_in_run", 64'(lo), 64'd14);
    check("busy_in_run", 64'(busy), 1);
    wait_done("divu_ignore_start");

    // MTHI/MTLO in IDLE
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthi_mtlo", {hi, lo}, {32'h1234, 32'h1234});
    lo_we = 1'b1; wdata = 32'h55;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_only", {hi, lo}, {32'h1234, 32'h55});

    // write coinciding with start is dropped
    hi_we = 1'b1; wdata = 32'hBEEF;
    issue(2'b01, 32'd2, 32'd3, 64'd6, 33, 1, 0);
    hi_we = 1'b0;
    check("mthi_with_start", 64'(hi), 64'h1234);
    wait_done("multu_2x3");

    // divide by zero
`ifdef MD_DIVZERO_EN
    issue(2'b11, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, DZ_LAT, 1, 1);
`else
    issue(2'b11, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, DZ_LAT, 0, 1);
`endif
    wait_done("divu_5_0");

    // asynchronous reset mid-MULT
    issue(2'b00, 32'd5, 32'd6, 64'd30, 33, 1, 0);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 0);
    check("abort_done", 64'(done), 0);
    check("abort_hilo", {hi, lo}, 0);
    exp_q.delete(); exp_cyc_q.delete(); exp_chk_q.delete(); exp_dz_q.delete();
    begin
      int snap;
      snap = done_count;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("no_done_after_abort", 64'(done_count), 64'(snap));
      check("idle_after_abort", 64'(dbg_state), 64'(ST_IDLE));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
